// File: rtl/image_stream_tx.sv
// Frame-to-stream transmitter: snapshots a 32x32 binary frame on start and streams it
// raster-order, BEAT_W pixels per beat, over valid/ready while counting set pixels.
module image_stream_tx #(
    parameter int unsigned BEAT_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1023:0]       frame,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [BEAT_W-1:0]   pix_data,
    output logic [4:0]          pix_row,
    output logic [4:0]          pix_col,
    output logic                pix_last,
    output logic                busy,
    output logic                done,
    output logic [10:0]         ones_count
);

    localparam int unsigned FRAME_W  = 1024;
    localparam int unsigned POS_W    = 5;
    localparam int unsigned CNT_W    = 11;
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(32 - BEAT_W);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(31);
    localparam logic [POS_W-1:0] COL_STEP = POS_W'(BEAT_W);

    generate
        if (BEAT_W != 1 && BEAT_W != 2 && BEAT_W != 4 &&
            BEAT_W != 8 && BEAT_W != 16 && BEAT_W != 32) begin : g_bad_beat_w
            $error("image_stream_tx: BEAT_W must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [FRAME_W-1:0]   shadow;
    logic                 xfer_c;
    logic [POS_W-1:0]     col_nxt_c;
    logic [POS_W-1:0]     row_nxt_c;
    logic                 last_nxt_c;

    // The current beat always sits at the top of the shadow register, pixel k of the beat
    // being bit FRAME_W-1-k; each transfer shifts the frame up by one beat.
    for (genvar k = 0; k < int'(BEAT_W); k++) begin : g_data
        assign pix_data[k] = shadow[FRAME_W-1-k];
    end

    assign xfer_c     = pix_valid && pix_ready;
    assign col_nxt_c  = POS_W'(pix_col + COL_STEP);
    assign row_nxt_c  = (pix_col == LAST_COL) ? POS_W'(pix_row + POS_W'(1)) : pix_row;
    assign last_nxt_c = (row_nxt_c == LAST_ROW) && (col_nxt_c == LAST_COL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (xfer_c && pix_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered status and datapath; an aborted beat still counts if its handshake was met.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pix_last   <= 1'b0;
            pix_row    <= '0;
            pix_col    <= '0;
            ones_count <= '0;
            shadow     <= '0;
        end else begin
            pix_valid <= (state_nxt == ST_SEND);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
            if (state == ST_IDLE && start) begin
                shadow     <= frame;
                pix_row    <= '0;
                pix_col    <= '0;
                pix_last   <= 1'b0;
                ones_count <= '0;
            end else if (state == ST_SEND && xfer_c) begin
                shadow     <= shadow << BEAT_W;
                pix_row    <= row_nxt_c;
                pix_col    <= col_nxt_c;
                pix_last   <= last_nxt_c;
                ones_count <= CNT_W'(ones_count + CNT_W'($countones(pix_data)));
            end
        end
    end

endmodule

// File: tb/tb_image_stream_tx.sv
// Self-checking bench for image_stream_tx: BEAT_W=8 table vectors plus BEAT_W=1 randomized
// handshake runs scored against a raster-order reference model.
module tb_image_stream_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start1, abort1, ready1, valid1, last1, busy1, done1;
    logic [1023:0] frame1;
    logic [0:0]    data1;
    logic [4:0]    row1, col1;
    logic [10:0]   cnt1;

    logic          start8, abort8, ready8, valid8, last8, busy8, done8;
    logic [1023:0] frame8;
    logic [7:0]    data8;
    logic [4:0]    row8, col8;
    logic [10:0]   cnt8;

    image_stream_tx #(.BEAT_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .frame(frame1),
        .pix_valid(valid1), .pix_ready(ready1), .pix_data(data1), .pix_row(row1),
        .pix_col(col1), .pix_last(last1), .busy(busy1), .done(done1), .ones_count(cnt1)
    );

    image_stream_tx #(.BEAT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .frame(frame8),
        .pix_valid(valid8), .pix_ready(ready8), .pix_data(data8), .pix_row(row8),
        .pix_col(col8), .pix_last(last8), .busy(busy8), .done(done8), .ones_count(cnt8)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [1023:0] frame;
        logic [7:0]    first_d;
        logic [7:0]    last_d;
        int            ones;
    } vec8_t;

    // BEAT_W=8, continuous ready: every beat against the model, done exactly at cycle 129.
    task automatic run8(input logic [1023:0] f, output logic [7:0] first_d,
                        output logic [7:0] last_d, output int ones_act);
        logic [7:0] ed;
        first_d = '0;
        last_d  = '0;
        @(negedge clk); frame8 = f; start8 = 1'b1; ready8 = 1'b1;
        @(negedge clk); start8 = 1'b0; frame8 = ~f;
        for (int b = 0; b < 128; b++) begin
            for (int k = 0; k < 8; k++) ed[k] = f[1023-(b*8+k)];
            chk("b8_valid", valid8, 1);
            chk("b8_row", row8, (b*8)/32);
            chk("b8_col", col8, (b*8)%32);
            chk("b8_data", data8, ed);
            chk("b8_last", last8, (b == 127) ? 1 : 0);
            chk("b8_done_early", done8, 0);
            if (b == 0) first_d = data8;
            if (b == 127) last_d = data8;
            @(negedge clk);
        end
        chk("b8_done", done8, 1);
        chk("b8_valid_after", valid8, 0);
        ones_act = int'(cnt8);
        @(negedge clk);
        chk("b8_done_pulse", done8, 0);
        chk("b8_busy_idle", busy8, 0);
    endtask

    // BEAT_W=1 frame with random ready; optional ignored restart, abort or mid-frame reset.
    task automatic run1(input logic [1023:0] f, input int pct, input int abort_at,
                        input int restart_at, input int reset_at, input bit scramble,
                        input bit abort_on_start);
        int beat, ones, cyc;
        bit xf, ab, fin;
        beat = 0; ones = 0; cyc = 0; fin = 0;
        @(negedge clk); frame1 = f; start1 = 1'b1; abort1 = abort_on_start;
        @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
        while (!fin && cyc < 8000) begin
            if (beat == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", valid1, 0);
                chk("rst_busy", busy1, 0);
                chk("rst_done", done1, 0);
                chk("rst_cnt", cnt1, 0);
                chk("rst_row", row1, 0);
                chk("rst_col", col1, 0);
                chk("rst_data", data1, 0);
                chk("rst_last", last1, 0);
                @(negedge clk); rst_n = 1'b1;
                @(negedge clk);
                chk("rst_idle_busy", busy1, 0);
                chk("rst_idle_done", done1, 0);
                fin = 1;
            end else begin
                chk("b1_valid", valid1, 1);
                chk("b1_row", row1, beat / 32);
                chk("b1_col", col1, beat % 32);
                chk("b1_data", data1, f[1023-beat]);
                chk("b1_last", last1, (beat == 1023) ? 1 : 0);
                chk("b1_cnt", cnt1, ones);
                chk("b1_busy", busy1, 1);
                chk("b1_done_early", done1, 0);
                xf = ($urandom_range(0, 99) < pct);
                ready1 = xf;
                if (scramble) frame1 = {32{$urandom()}};
                start1 = (beat == restart_at);
                ab = (beat == abort_at);
                abort1 = ab;
                @(negedge clk);
                cyc++;
                start1 = 1'b0; abort1 = 1'b0;
                if (xf) begin
                    ones += int'(f[1023-beat]);
                    beat++;
                end
                if (ab) begin
                    chk("abort_valid", valid1, 0);
                    chk("abort_busy", busy1, 0);
                    chk("abort_done", done1, 0);
                    chk("abort_cnt", cnt1, ones);
                    @(negedge clk);
                    chk("abort_no_done", done1, 0);
                    chk("abort_cnt_hold", cnt1, ones);
                    fin = 1;
                end else if (beat == 1024) begin
                    chk("b1_done", done1, 1);
                    chk("b1_valid_after", valid1, 0);
                    chk("b1_cnt_final", cnt1, ones);
                    if (pct == 100) chk("b1_latency", cyc, 1024);
                    ready1 = 1'b0;
                    @(negedge clk);
                    chk("b1_done_pulse", done1, 0);
                    chk("b1_busy_idle", busy1, 0);
                    @(negedge clk);
                    chk("b1_cnt_hold", cnt1, ones);
                    fin = 1;
                end
            end
        end
        if (!fin) begin
            n_chk++;
            $display("FAIL run1_timeout: got beat %0d expected 1024 within 8000 cycles", beat);
        end
    endtask

    vec8_t         tbl [5];
    logic [1023:0] cb;
    logic [1023:0] fr;
    logic [7:0]    fd, ld;
    int            oa;

    initial begin
        start1 = 0; abort1 = 0; ready1 = 0; frame1 = '0;
        start8 = 0; abort8 = 0; ready8 = 0; frame8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid1", valid1, 0);
        chk("reset_busy1", busy1, 0);
        chk("reset_cnt1", cnt1, 0);
        chk("reset_valid8", valid8, 0);
        chk("reset_data8", data8, 0);
        chk("reset_last8", last8, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy8", busy8, 0);
        chk("idle_done8", done8, 0);

        cb = '0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                cb[1023-(32*r+c)] = 1'((r + c) % 2);
        tbl[0] = '{frame: '0,   first_d: 8'h00, last_d: 8'h00, ones: 0};
        tbl[1] = '{frame: '1,   first_d: 8'hFF, last_d: 8'hFF, ones: 1024};
        tbl[2] = '{frame: cb,   first_d: 8'hAA, last_d: 8'h55, ones: 512};
        tbl[3] = '{frame: '0,   first_d: 8'h08, last_d: 8'h00, ones: 1};
        tbl[3].frame[1023-3] = 1'b1;
        tbl[4] = '{frame: '0,   first_d: 8'h00, last_d: 8'h80, ones: 1};
        tbl[4].frame[0] = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run8(tbl[i].frame, fd, ld, oa);
            chk("tbl_first_data", fd, tbl[i].first_d);
            chk("tbl_last_data", ld, tbl[i].last_d);
            chk("tbl_ones", oa, tbl[i].ones);
        end

        run1('1, 100, -1, -1, -1, 1'b0, 1'b0);
        chk("all_ones_1024", cnt1, 1024);

        fr = '0;
        fr[1023-167] = 1'b1;
        run1(fr, 100, -1, -1, -1, 1'b0, 1'b1);
        chk("single_pixel_cnt", cnt1, 1);

        run1({32{$urandom()}}, 50, -1, -1, -1, 1'b1, 1'b0);
        run1({32{$urandom()}}, 70, 500, 300, -1, 1'b1, 1'b0);
        run1({32{$urandom()}}, 100, -1, -1, -1, 1'b1, 1'b0);
        run1({32{$urandom()}}, 80, -1, -1, 700, 1'b0, 1'b0);
        run1({32{$urandom()}}, 100, -1, -1, -1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/image_stream_tx.md
Name: image_stream_tx

Overview:
- Frame-to-stream transmitter for the 32x32 binary digit image.
- On `start`, snapshots the 1024-bit processed frame produced by the dilation stage (network-order packing) and streams it raster-order, `BEAT_W` pixels per beat, over a valid/ready handshake toward the DNN input stage.
- Counts transmitted set pixels and reports frame completion.

Parameters:
- BEAT_W, 1, pixels per beat; legal values 1, 2, 4, 8, 16, 32; any other value is a configuration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low (already decided).
- start  input  1  one-cycle request to capture `frame` and begin transmission; honoured only in IDLE.
- abort  input  1  synchronous cancel of the frame in progress.
- frame  input  1024  processed image; pixel (r,c) is at bit 1023-(32*r+c).
- pix_valid  output  1  beat available.
- pix_ready  input  1  downstream accepts beat.
- pix_data  output  BEAT_W  bit k = pixel (row, col+k).
- pix_row  output  5  row of the current beat.
- pix_col  output  5  first column of the current beat; always a multiple of BEAT_W.
- pix_last  output  1  current beat is the final beat of the frame.
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse after the last beat transfers.
- ones_count  output  11  number of 1 pixels transferred in the current or last frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - All outputs 0, shadow register 0, counters 0.
- States: IDLE, SEND, DONE.
- IDLE:
  - `start` high at edge N: latch `frame` into the shadow register, clear row/col/ones_count, go to SEND.
  - `pix_valid` = 1 from cycle N+1; the first beat is (0,0).
- SEND:
  - A transfer occurs at a rising edge where `pix_valid` && `pix_ready`.
  - On transfer: `ones_count` += popcount(`pix_data`); col += BEAT_W; when col wraps past 31 it returns to 0 and row increments.
  - While `pix_valid` && !`pix_ready`: `pix_data`, `pix_row`, `pix_col`, `pix_last` held stable.
  - `pix_valid` never drops once raised until the last beat transfers or abort.
  - `pix_last` = (row == 31) && (col == 32-BEAT_W).
  - Transfer of the last beat -> DONE; `pix_valid` = 0 the next cycle.
- DONE:
  - `done` = 1 for exactly one cycle, then IDLE.
  - `ones_count` holds its final value (max 1024) until the next accepted start.
- `start` in SEND or DONE: ignored; the shadow register is unchanged.
- `abort` high in SEND or DONE: IDLE next cycle.
  - `pix_valid` = 0, no `done` pulse.
  - `ones_count` holds the partial count.
  - `abort` has priority over a coincident transfer; that beat is counted as transferred only if the handshake was met at that edge.
- `abort` and `start` together in IDLE: `start` wins and a frame begins.
- Changes on `frame` after capture have no effect on the frame in flight.
- Beats per frame = 1024/BEAT_W.
- Throughput: one beat per cycle with `pix_ready` held high.
  - Frame latency with continuous ready: start edge N -> last transfer at edge N+1024/BEAT_W, `done` high during cycle N+1+1024/BEAT_W.
- Reset asserted mid-frame: outputs clear immediately; no `done`; after release the block sits in IDLE awaiting `start`.

Test Plan:
- BEAT_W=1, `frame` all ones, `pix_ready` = 1, start at edge 0 -> 1024 transfers at edges 1..1024; `pix_last` only on (31,31); `done` during cycle 1025; `ones_count` = 1024; `busy` low from cycle 1026.
- BEAT_W=1, only pixel (5,7) set (bit 1023-167) -> `pix_data` = 1 only on beat 167 with row=5, col=7; `ones_count` = 1.
- BEAT_W=8, checkerboard (pixel = (r+c)&1) -> 128 beats; each beat data 8'hAA on even rows, 8'h55 on odd rows (bit k = col+k); `ones_count` = 512; last beat row=31, col=24.
- BEAT_W=1, `pix_ready` pseudo-random 50% duty -> data, row and col stable during stalls; no beat lost or duplicated; scoreboard matches the captured frame even though `frame` changes after start.
- start pulsed again at beat 300 -> ignored, frame completes unchanged; abort at beat 500 -> IDLE, no `done`, `ones_count` = partial count; new start works normally.
- rst_n low at beat 700 -> all outputs 0 asynchronously; after release, start completes a full frame correctly.
